// File: rtl/crc_fcs_insert.sv
// crc_fcs_insert: passes an AXI-Stream byte stream through and appends an
// Ethernet-style CRC-32 FCS. Frames shorter than MIN_FRAME_LEN are zero-padded
// first. The CRC covers payload and pad, is reflected (LSB-first per byte),
// and is sent inverted, least-significant byte first.
module crc_fcs_insert #(
  parameter logic [31:0] LFSR_POLY     = 32'h04c11db7,
  parameter logic [31:0] LFSR_INIT     = 32'hffffffff,
  parameter int          MIN_FRAME_LEN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       busy
);

  typedef enum logic [1:0] {
    PAYLOAD = 2'd0,
    PAD     = 2'd1,
    FCS     = 2'd2
  } state_t;

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);

  // One byte of reflected Galois CRC: data bit 0 enters first, so the
  // polynomial is applied in bit-reversed form.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] rpoly;
    logic [31:0] c;
    for (int i = 0; i < 32; i++) begin
      rpoly[i] = LFSR_POLY[31-i];
    end
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ rpoly;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] crc_r, crc_s;
  logic [15:0] count_r, count_s;
  logic [1:0]  fcs_idx_r, fcs_idx_s;
  logic [7:0]  data_r, data_s;
  logic        valid_r, valid_s;
  logic        last_r, last_s;
  logic        busy_r, busy_s;

  logic        load_s;
  logic        ready_s;
  logic        in_xfer_s;
  logic [16:0] cnt_inc_s;
  logic [15:0] cnt_sat_s;
  logic [31:0] fcs_all_s;
  logic [7:0]  fcs_byte_s;

  // Next-state, datapath and handshake decode; everything holds by default,
  // which is exactly the back-pressure behaviour.
  always_comb begin
    state_s    = state_r;
    crc_s      = crc_r;
    count_s    = count_r;
    fcs_idx_s  = fcs_idx_r;
    data_s     = data_r;
    valid_s    = valid_r;
    last_s     = last_r;
    busy_s     = busy_r;

    load_s     = !valid_r || m_axis_tready;
    ready_s    = (state_r == PAYLOAD) && load_s && !rst;
    in_xfer_s  = s_axis_tvalid && ready_s;
    cnt_inc_s  = {1'b0, count_r} + 17'd1;
    cnt_sat_s  = (count_r < MIN_LEN) ? cnt_inc_s[15:0] : count_r;
    fcs_all_s  = ~crc_r;

    case (fcs_idx_r)
      2'd0:    fcs_byte_s = fcs_all_s[7:0];
      2'd1:    fcs_byte_s = fcs_all_s[15:8];
      2'd2:    fcs_byte_s = fcs_all_s[23:16];
      2'd3:    fcs_byte_s = fcs_all_s[31:24];
      default: fcs_byte_s = 8'h00;
    endcase

    case (state_r)
      PAYLOAD: begin
        if (in_xfer_s) begin
          data_s  = s_axis_tdata;
          valid_s = 1'b1;
          last_s  = 1'b0;
          crc_s   = crc_byte(crc_r, s_axis_tdata);
          count_s = cnt_sat_s;
          if (s_axis_tlast) begin
            fcs_idx_s = 2'd0;
            if (cnt_inc_s < {1'b0, MIN_LEN}) begin
              state_s = PAD;
            end else begin
              state_s = FCS;
            end
          end else begin
            state_s = PAYLOAD;
          end
        end else if (load_s) begin
          valid_s = 1'b0;
          last_s  = 1'b0;
        end else begin
          valid_s = valid_r;
        end
      end
      PAD: begin
        if (load_s) begin
          data_s  = 8'h00;
          valid_s = 1'b1;
          last_s  = 1'b0;
          crc_s   = crc_byte(crc_r, 8'h00);
          count_s = cnt_sat_s;
          if (cnt_inc_s >= {1'b0, MIN_LEN}) begin
            state_s   = FCS;
            fcs_idx_s = 2'd0;
          end else begin
            state_s = PAD;
          end
        end else begin
          state_s = PAD;
        end
      end
      FCS: begin
        if (load_s) begin
          data_s  = fcs_byte_s;
          valid_s = 1'b1;
          last_s  = (fcs_idx_r == 2'd3);
          if (fcs_idx_r == 2'd3) begin
            state_s   = PAYLOAD;
            crc_s     = LFSR_INIT;
            count_s   = 16'd0;
            fcs_idx_s = 2'd0;
          end else begin
            fcs_idx_s = fcs_idx_r + 2'd1;
          end
        end else begin
          state_s = FCS;
        end
      end
      default: begin
        state_s = PAYLOAD;
      end
    endcase

    // A new frame's first byte can be accepted in the same cycle the previous
    // frame's final FCS byte leaves, so setting wins over clearing.
    if (in_xfer_s) begin
      busy_s = 1'b1;
    end else if (valid_r && m_axis_tready && last_r) begin
      busy_s = 1'b0;
    end else begin
      busy_s = busy_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= PAYLOAD;
      crc_r     <= LFSR_INIT;
      count_r   <= 16'd0;
      fcs_idx_r <= 2'd0;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      last_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      crc_r     <= crc_s;
      count_r   <= count_s;
      fcs_idx_r <= fcs_idx_s;
      data_r    <= data_s;
      valid_r   <= valid_s;
      last_r    <= last_s;
      busy_r    <= busy_s;
    end
  end

  assign s_axis_tready = ready_s;
  assign m_axis_tdata  = data_r;
  assign m_axis_tvalid = valid_r;
  assign m_axis_tlast  = last_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_crc_fcs_insert.sv
// Bench for crc_fcs_insert: two instances (MIN_FRAME_LEN=60 as index 0,
// MIN_FRAME_LEN=0 as index 1) share one driver. A byte-level reference model
// fills a scoreboard queue per instance when each frame is driven, and a
// monitor pops and compares on every output transfer.
module tb_crc_fcs_insert;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] drv_data;
  logic       drv_valid;
  logic       drv_last;
  logic       dsel;
  logic       m_tready;
  logic       rand_rdy;

  logic       tv_pad, tv_nopad;
  logic       rdy_pad, rdy_nopad;
  logic [7:0] od_pad, od_nopad;
  logic       ov_pad, ov_nopad;
  logic       ol_pad, ol_nopad;
  logic       busy_pad, busy_nopad;

  assign tv_pad   = drv_valid && (dsel == 1'b0);
  assign tv_nopad = drv_valid && (dsel == 1'b1);

  always #5 clk = ~clk;

  crc_fcs_insert #(.MIN_FRAME_LEN(60)) u_pad (
    .clk(clk), .rst(rst),
    .s_axis_tdata(drv_data), .s_axis_tvalid(tv_pad), .s_axis_tready(rdy_pad), .s_axis_tlast(drv_last),
    .m_axis_tdata(od_pad), .m_axis_tvalid(ov_pad), .m_axis_tready(m_tready), .m_axis_tlast(ol_pad),
    .busy(busy_pad)
  );

  crc_fcs_insert #(.MIN_FRAME_LEN(0)) u_nopad (
    .clk(clk), .rst(rst),
    .s_axis_tdata(drv_data), .s_axis_tvalid(tv_nopad), .s_axis_tready(rdy_nopad), .s_axis_tlast(drv_last),
    .m_axis_tdata(od_nopad), .m_axis_tvalid(ov_nopad), .m_axis_tready(m_tready), .m_axis_tlast(ol_nopad),
    .busy(busy_nopad)
  );

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc      = 0;

  logic [8:0]  q_pad [$];
  logic [8:0]  q_nopad [$];
  logic [7:0]  fbuf [0:255];

  int          frames_done [2];
  int          flen [2];
  int          olen [2];
  int          span [2];
  int          gap [2];
  int          start_cyc [2];
  int          prev_last_cyc [2];
  bit          started [2];
  bit          stall [2];
  logic [7:0]  stall_data [2];
  logic        stall_last [2];
  logic [31:0] last4 [2];

  typedef struct {
    bit          sel;
    int          len;
    logic [7:0]  base;
    int          exp_len;
    bit          has_fcs;
    logic [31:0] exp_fcs;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  endtask

  function automatic logic [31:0] model_crc(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in;
    for (int j = 0; j < 8; j++) begin
      if (c[0] ^ b[j]) c = (c >> 1) ^ 32'hEDB88320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  task automatic q_push(input bit d, input logic [8:0] v);
    if (d) q_nopad.push_back(v);
    else   q_pad.push_back(v);
  endtask

  function automatic int q_size(input bit d);
    return d ? q_nopad.size() : q_pad.size();
  endfunction

  // Reference model: payload, zero pad up to 60 bytes on instance 0, then ~CRC LSB first.
  task automatic push_expected(input bit d, input int len);
    int          n;
    logic [31:0] c;
    logic [7:0]  b;
    n = len;
    c = 32'hFFFFFFFF;
    if (!d && n < 60) n = 60;
    for (int i = 0; i < n; i++) begin
      b = (i < len) ? fbuf[i] : 8'h00;
      c = model_crc(c, b);
      q_push(d, {1'b0, b});
    end
    c = ~c;
    for (int k = 0; k < 4; k++) begin
      q_push(d, {(k == 3), 8'(c >> (8 * k))});
    end
  endtask

  // Drive one frame from fbuf; returns at posedge+1 after the last byte is accepted.
  task automatic send_frame(input bit d, input int len, input bit gaps);
    bit acc;
    int to;
    push_expected(d, len);
    dsel = d;
    for (int i = 0; i < len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          drv_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      drv_valid = 1'b1;
      drv_data  = fbuf[i];
      drv_last  = (i == len - 1);
      acc = 1'b0;
      to  = 0;
      while (!acc) begin
        @(negedge clk);
        acc = d ? rdy_nopad : rdy_pad;
        @(posedge clk); #1;
        to++;
        if (!acc && to > 2000) begin
          check("timeout_accept", 64'(to), 64'd0);
          finish_run();
        end
      end
    end
    drv_valid = 1'b0;
    drv_last  = 1'b0;
  endtask

  task automatic wait_frames(input int d, input int n, input int budget);
    int t;
    t = 0;
    while (frames_done[d] < n) begin
      @(posedge clk); #1;
      t++;
      if (t > budget) begin
        check("timeout_frames", 64'(frames_done[d]), 64'(n));
        finish_run();
      end
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [7:0] dat, input logic l);
    logic [8:0] e;
    if (stall[d]) begin
      check("stall_hold", {v, l, dat}, {1'b1, stall_last[d], stall_data[d]});
    end
    if (v && m_tready) begin
      if (q_size(d[0]) == 0) begin
        check("unexpected_output", {l, dat}, 9'h1ff);
      end else begin
        e = d[0] ? q_nopad.pop_front() : q_pad.pop_front();
        check("out_byte", {l, dat}, e);
      end
      last4[d] = {dat, last4[d][31:8]};
      if (!started[d]) begin
        started[d]   = 1'b1;
        start_cyc[d] = cyc;
        gap[d]       = cyc - prev_last_cyc[d];
      end
      olen[d]++;
      if (l) begin
        span[d]          = cyc - start_cyc[d] + 1;
        flen[d]          = olen[d];
        olen[d]          = 0;
        started[d]       = 1'b0;
        prev_last_cyc[d] = cyc;
        frames_done[d]++;
      end
    end
    stall[d]      = v && !m_tready;
    stall_data[d] = dat;
    stall_last[d] = l;
  endtask

  // Monitor: compare every output transfer of both instances.
  initial begin
    for (int d = 0; d < 2; d++) begin
      frames_done[d] = 0; flen[d] = 0; olen[d] = 0; span[d] = 0; gap[d] = 0;
      start_cyc[d] = 0; prev_last_cyc[d] = 0; started[d] = 1'b0; stall[d] = 1'b0;
      stall_data[d] = 8'h00; stall_last[d] = 1'b0; last4[d] = 32'h0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q_pad.delete();
        q_nopad.delete();
        for (int d = 0; d < 2; d++) begin
          started[d] = 1'b0; stall[d] = 1'b0; olen[d] = 0;
        end
      end else begin
        mon(0, ov_pad, od_pad, ol_pad);
        mon(1, ov_nopad, od_nopad, ol_nopad);
      end
    end
  end

  // Downstream ready: always 1 or random 50% duty.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    vec_t vecs [7];
    int   nd;
    int   len;

    vecs[0] = '{1'b1,   9, 8'h31, 13, 1'b1, 32'hCBF43926};
    vecs[1] = '{1'b0,   1, 8'hAA, 64, 1'b0, 32'h0};
    vecs[2] = '{1'b0,  59, 8'h10, 64, 1'b0, 32'h0};
    vecs[3] = '{1'b0,  60, 8'h20, 64, 1'b0, 32'h0};
    vecs[4] = '{1'b0,  61, 8'h05, 65, 1'b0, 32'h0};
    vecs[5] = '{1'b1,   1, 8'h00,  5, 1'b1, 32'hD202EF8D};
    vecs[6] = '{1'b0, 100, 8'h80, 104, 1'b0, 32'h0};

    rst = 1'b1; drv_data = 8'h00; drv_valid = 1'b0; drv_last = 1'b0;
    dsel = 1'b0; rand_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("tready_in_reset", {rdy_pad, rdy_nopad}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_tready", {rdy_pad, rdy_nopad}, 2'b11);
    check("reset_busy", {busy_pad, busy_nopad}, 2'b00);
    check("reset_tvalid", {ov_pad, ov_nopad}, 2'b00);
    check("reset_tdata_tlast", {od_pad, ol_pad}, 9'h000);
    @(posedge clk); #1;

    // Table of directed frames with all-ready output.
    for (int v = 0; v < 7; v++) begin
      nd = frames_done[vecs[v].sel];
      for (int i = 0; i < vecs[v].len; i++) fbuf[i] = 8'(vecs[v].base + 8'(i));
      send_frame(vecs[v].sel, vecs[v].len, 1'b0);
      wait_frames(int'(vecs[v].sel), nd + 1, 5000);
      check("frame_len", 64'(flen[vecs[v].sel]), 64'(vecs[v].exp_len));
      check("frame_span", 64'(span[vecs[v].sel]), 64'(vecs[v].exp_len));
      check("queue_empty", 64'(q_size(vecs[v].sel)), 64'd0);
      if (vecs[v].has_fcs) check("fcs_known", last4[vecs[v].sel], vecs[v].exp_fcs);
    end

    // busy and tready around a padded single-byte frame.
    nd = frames_done[0];
    fbuf[0] = 8'h55;
    send_frame(1'b0, 1, 1'b0);
    @(negedge clk);
    check("busy_during_frame", busy_pad, 1'b1);
    check("tready_low_in_pad", rdy_pad, 1'b0);
    @(posedge clk); #1;
    wait_frames(0, nd + 1, 5000);
    @(negedge clk);
    check("busy_after_frame", busy_pad, 1'b0);
    @(posedge clk); #1;

    // Back-to-back 60- and 61-byte frames: no padding, no bubble between.
    nd = frames_done[0];
    for (int i = 0; i < 60; i++) fbuf[i] = 8'(i * 3 + 1);
    send_frame(1'b0, 60, 1'b0);
    for (int i = 0; i < 61; i++) fbuf[i] = 8'(8'hF0 - 8'(i));
    send_frame(1'b0, 61, 1'b0);
    wait_frames(0, nd + 2, 5000);
    check("b2b_len", 64'(flen[0]), 64'd65);
    check("b2b_span", 64'(span[0]), 64'd65);
    check("b2b_gap", 64'(gap[0]), 64'd1);

    // Reset in the middle of the FCS of frame A, then "123456789".
    for (int i = 0; i < 20; i++) fbuf[i] = 8'(8'h60 + 8'(i));
    send_frame(1'b1, 20, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_tvalid", {ov_nopad, busy_nopad}, 2'b00);
    @(posedge clk); #1;
    nd = frames_done[1];
    for (int i = 0; i < 9; i++) fbuf[i] = 8'(8'h31 + 8'(i));
    send_frame(1'b1, 9, 1'b0);
    wait_frames(1, nd + 1, 5000);
    check("after_abort_fcs", last4[1], 32'hCBF43926);
    check("after_abort_len", 64'(flen[1]), 64'd13);

    // Random frames with random back-pressure and input gaps.
    rand_rdy = 1'b1;
    nd = frames_done[0];
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 200);
      for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom_range(0, 255));
      send_frame(1'b0, len, 1'b1);
    end
    wait_frames(0, nd + 200, 60000);
    rand_rdy = 1'b0;
    check("random_queue_empty", 64'(q_size(1'b0)), 64'd0);

    @(posedge clk); #1;
    finish_run();
  end

endmodule
